// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; raises busy for a fixed latency per op.
// Optional MADD/MADDU accumulate ops (op 6/7) are enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [63:0]   shadow, shadow_n;
  logic [31:0]   hi_n, lo_n;

  // Multiply datapath: sign- or zero-extend to 64 bits so one multiplier serves both.
  logic        mult_signed;
  logic [63:0] a_ext, b_ext, prod;

  assign mult_signed = (op == OP_MULT) || (op == OP_MADD);
  assign a_ext       = {{32{mult_signed & a[31]}}, a};
  assign b_ext       = {{32{mult_signed & b[31]}}, b};
  assign prod        = a_ext * b_ext;

  // Divide datapath: magnitude divide, then restore signs (quotient truncates to zero,
  // remainder follows the dividend). 0x80000000 / -1 wraps naturally to 0x80000000.
  logic        div_signed, a_neg, b_neg, div_zero;
  logic [31:0] abs_a, abs_b, div_b, q_mag, r_mag, quot, rem;
  logic [63:0] div_res;

  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign abs_a      = a_neg ? (~a + 32'd1) : a;
  assign abs_b      = b_neg ? (~b + 32'd1) : b;
  assign div_zero   = (b == 32'd0);
  assign div_b      = div_zero ? 32'd1 : abs_b;
  assign q_mag      = abs_a / div_b;
  assign r_mag      = abs_a % div_b;
  assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
  // A zero divisor commits the current HI/LO, which cannot change while busy.
  assign div_res    = div_zero ? {hi, lo} : {rem, quot};

  assign busy = (state == RUN);

  always_comb begin
    state_n  = state;
    count_n  = count;
    shadow_n = shadow;
    hi_n     = hi;
    lo_n     = lo;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              shadow_n = prod;
              count_n  = MULT_LOAD;
              state_n  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              shadow_n = div_res;
              count_n  = DIV_LOAD;
              state_n  = RUN;
            end
            OP_MTHI: hi_n = a;
            OP_MTLO: lo_n = a;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: begin
              shadow_n = {hi, lo} + prod;
              count_n  = MULT_LOAD;
              state_n  = RUN;
            end
`else
            OP_MADD, OP_MADDU: ;
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        // Cancel outranks the commit on the final cycle.
        if (cancel) begin
          state_n = IDLE;
          count_n = '0;
        end else if (count == '0) begin
          {hi_n, lo_n} = shadow;
          state_n      = IDLE;
        end else begin
          count_n = count - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      shadow <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      shadow <= shadow_n;
      hi     <= hi_n;
      lo     <= lo_n;
    end
  end

endmodule
